// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM serial receive path.
// Optional build macro: TDM_PARITY_EN adds one even-parity slot per frame.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int NCH_DEFAULT = 8;

  // Number of slots on the wire per frame: data slots plus the optional parity slot.
  function automatic int frame_len(input int nch);
`ifdef TDM_PARITY_EN
    return nch + 1;
`else
    return nch;
`endif
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position counter for one TDM frame: counts 0..FLEN-1 and wraps,
// can be forced to 1 when a frame marker is accepted as slot 0.
module tdm_slot_counter #(
  parameter int FLEN = 8,
  parameter int W    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load1,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = (cnt == W'(FLEN - 1));

  // Advance one slot per accepted beat; a frame marker restarts the count at slot 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= W'(1);
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM serial receiver: locks to the frame marker, steers each slot bit into
// its channel position and presents the recovered word with a valid strobe.
// Optional build macro: TDM_PARITY_EN (extra parity slot and parity_err output).
module tdm_demux_rx
  import tdm_pkg::*;
#(
  parameter int NCH  = NCH_DEFAULT,
  parameter int SELW = $clog2(frame_len(NCH))
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            din,
  input  logic            din_valid,
  input  logic            frame_sync,
  output logic [NCH-1:0]  dout,
  output logic            dout_valid,
  output logic [SELW-1:0] slot_sel,
  output logic            locked,
  output logic            frame_err
`ifdef TDM_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int FLEN = frame_len(NCH);

  state_t          state;
  logic [NCH-1:0]  shadow;
  logic [NCH-1:0]  shadow_nxt;
  logic [NCH-1:0]  shadow_first;
  logic            cnt_en;
  logic            cnt_load;
  logic            wrap;

  // The marker beat is accepted as slot 0 in either state; ordinary beats only advance while locked.
  assign cnt_load = din_valid && frame_sync;
  assign cnt_en   = din_valid && (state == LOCK) && !frame_sync && (slot_sel != '0);

  tdm_slot_counter #(
    .FLEN (FLEN),
    .W    (SELW)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .load1 (cnt_load),
    .cnt   (slot_sel),
    .wrap  (wrap)
  );

  assign locked       = (state == LOCK);
  assign shadow_first = {{(NCH-1){1'b0}}, din};

  // Steer the incoming bit into the channel addressed by the current slot; the parity slot matches no channel.
  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < NCH; k++) begin
      if (slot_sel == SELW'(k)) shadow_nxt[k] = din;
    end
  end

  // Frame-lock FSM with shadow assembly and output word register; pulses clear on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow <= shadow_first;
              state  <= LOCK;
            end
          end
          LOCK: begin
            if (frame_sync) begin
              // A marker anywhere but slot 0 abandons the partial frame and restarts it.
              frame_err <= (slot_sel != '0);
              shadow    <= shadow_first;
            end else if (slot_sel == '0) begin
              frame_err <= 1'b1;
              state     <= HUNT;
            end else begin
              shadow <= shadow_nxt;
              if (wrap) begin
`ifdef TDM_PARITY_EN
                // Even parity: the parity bit equals the XOR of the data bits.
                if (din == ^shadow) begin
                  dout       <= shadow;
                  dout_valid <= 1'b1;
                end else begin
                  parity_err <= 1'b1;
                end
`else
                dout       <= shadow_nxt;
                dout_valid <= 1'b1;
`endif
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Scoreboard bench for tdm_demux_rx: a frame-level model predicts events,
// a monitor compares them against the DUT on every falling edge.
module tb_tdm_demux_rx;
  import tdm_pkg::*;

  localparam int NCH  = 8;
  localparam int FL   = frame_len(NCH);
  localparam int SELW = $clog2(FL);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            din = 1'b0;
  logic            din_valid = 1'b0;
  logic            frame_sync = 1'b0;
  logic [NCH-1:0]  dout;
  logic            dout_valid;
  logic [SELW-1:0] slot_sel;
  logic            locked;
  logic            frame_err;
`ifdef TDM_PARITY_EN
  logic            parity_err;
`endif

  tdm_demux_rx #(.NCH(NCH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot_sel   (slot_sel),
    .locked     (locked),
    .frame_err  (frame_err)
`ifdef TDM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int             kind;   // 1 word, 2 frame error, 3 parity error
    logic [NCH-1:0] word;
  } ev_t;

  int tests = 0;
  int fails = 0;

  // Reference model state: lock flag, bits of the frame collected so far, last good word.
  bit             m_locked = 0;
  bit             m_bits[$];
  logic [NCH-1:0] m_word = '0;
  ev_t            exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [NCH-1:0] w);
    ev_t e;
    e.kind = kind;
    e.word = w;
    exp_q.push_back(e);
  endtask

  // Frame-level rules: a frame is a marker followed by FL-1 unmarked beats.
  task automatic model_beat(input bit s, input bit d);
    logic [NCH-1:0] w;
    if (!m_locked) begin
      if (s) begin
        m_locked = 1;
        m_bits = {d};
      end
    end else if (s) begin
      if (m_bits.size() != 0) push_ev(2, '0);
      m_bits = {d};
    end else if (m_bits.size() == 0) begin
      push_ev(2, '0);
      m_locked = 0;
    end else begin
      m_bits.push_back(d);
      if (m_bits.size() == FL) begin
        for (int k = 0; k < NCH; k++) w[k] = m_bits[k];
`ifdef TDM_PARITY_EN
        if ((^w) == m_bits[NCH]) begin
          m_word = w;
          push_ev(1, w);
        end else begin
          push_ev(3, '0);
        end
`else
        m_word = w;
        push_ev(1, w);
`endif
        m_bits.delete();
      end
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_bits.delete();
    m_word = '0;
    exp_q.delete();
  endtask

  // Monitor: each falling edge compares strobes against the queued expectation and state against the model.
  always @(negedge clk) begin
    ev_t e;
    bit  have;
    e.kind = 0;
    e.word = '0;
    have = (exp_q.size() > 0);
    if (have) e = exp_q.pop_front();
    chk("dout_valid", 64'(dout_valid), 64'(have && e.kind == 1));
    chk("frame_err", 64'(frame_err), 64'(have && e.kind == 2));
`ifdef TDM_PARITY_EN
    chk("parity_err", 64'(parity_err), 64'(have && e.kind == 3));
`endif
    chk("dout", 64'(dout), 64'(m_word));
    chk("locked", 64'(locked), 64'(m_locked));
    chk("slot_sel", 64'(slot_sel), 64'(m_locked ? m_bits.size() : 0));
  end

  task automatic idle_cycle();
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'($urandom);
    din        = 1'($urandom);
  endtask

  task automatic beat(input bit s, input bit d, input int gapmax);
    int g;
    g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
    for (int i = 0; i < g; i++) idle_cycle();
    @(negedge clk);
    din_valid  = 1'b1;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    model_beat(s, d);
  endtask

  // Sends nb beats of a frame carrying word w; sync0 selects the marker on beat 0.
  task automatic send_frame(input logic [NCH-1:0] w, input bit sync0, input int nb,
                            input int gapmax, input bit bad_par);
    bit d;
    for (int i = 0; i < nb; i++) begin
      d = (i < NCH) ? w[i] : ((^w) ^ bad_par);
      beat(sync0 && i == 0, d, gapmax);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    logic [NCH-1:0] w;
    int r;

    // Reset state
    #12;
    chk("reset dout", 64'(dout), 64'h0);
    chk("reset locked", 64'(locked), 64'h0);
    chk("reset slot_sel", 64'(slot_sel), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Slots 0..7 = 1,0,1,1,0,0,1,0
    send_frame(8'b0100_1101, 1, FL, 0, 0);
    chk("first word", 64'(dout), 64'h4D);
    chk("first locked", 64'(locked), 64'h1);

    // Back-to-back frames with gapped valid
    send_frame(8'hA5, 1, FL, 3, 0);
    send_frame(8'h3C, 1, FL, 3, 0);
    chk("gapped word", 64'(dout), 64'h3C);

    // Unmarked beats drop lock, then a marked frame relocks
    send_frame(8'h00, 0, FL, 1, 0);
    chk("hunt locked", 64'(locked), 64'h0);
    send_frame(8'hFF, 1, FL, 1, 0);
    chk("relock word", 64'(dout), 64'hFF);

    // Early marker at slot 4
    send_frame(8'h55, 1, 4, 0, 0);
    send_frame(8'h96, 1, FL, 0, 0);
    chk("after early sync", 64'(dout), 64'h96);

    // Missing marker on second frame
    send_frame(8'h12, 1, FL, 0, 0);
    send_frame(8'h34, 0, FL, 0, 0);
    chk("missing sync hold", 64'(dout), 64'h12);
    send_frame(8'h77, 1, FL, 2, 0);

`ifdef TDM_PARITY_EN
    // Corrupted parity bit
    send_frame(8'h6B, 1, FL, 0, 1);
    chk("bad parity hold", 64'(dout), 64'h77);
    send_frame(8'h6B, 1, FL, 0, 0);
`endif

    // Randomized frames with occasional framing faults
    for (int f = 0; f < 60; f++) begin
      w = NCH'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) send_frame(w, 0, FL, 2, 0);
      else if (r == 1) send_frame(w, 1, $urandom_range(1, FL - 1), 2, 0);
      else send_frame(w, 1, FL, 2, (r == 2) ? 1'b1 : 1'b0);
    end

    // Asynchronous reset in the middle of a frame
    send_frame(8'hC3, 1, FL, 0, 0);
    send_frame(8'h5A, 1, 5, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async rst dout", 64'(dout), 64'h0);
    chk("async rst slot_sel", 64'(slot_sel), 64'h0);
    chk("async rst locked", 64'(locked), 64'h0);
    chk("async rst dout_valid", 64'(dout_valid), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h81, 1, FL, 1, 0);
    chk("post reset word", 64'(dout), 64'h81);

    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
Receive end of the team's time-division serial link: the transmit side uses the mux tree to serialize NCH channel bits onto one wire, one slot per valid cycle. This block locks to the frame marker, steers each slot bit into its channel position (the demultiplexer counterpart of the mux tree) and presents the recovered parallel word with a one-cycle valid strobe. It sits between the serial link input and the consumer logic.

Parameters:
NCH, 8, channels (slots) per frame; legal 2..32
SELW, $clog2(NCH), width of the slot index

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
din  input  1  serial slot data
din_valid  input  1  din and frame_sync are sampled only when high
frame_sync  input  1  qualified by din_valid; marks slot 0 of a frame
dout  output  NCH  recovered word; bit k = slot k
dout_valid  output  1  one-cycle pulse: dout updated this cycle
slot_sel  output  SELW  slot index expected on the next valid beat
locked  output  1  high in LOCK state
frame_err  output  1  one-cycle pulse on sync violation

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=HUNT, slot_sel=0, shadow=0, dout=0, dout_valid=0, locked=0, frame_err=0.
- All state changes only on clk edges with din_valid=1; din_valid=0 cycles freeze everything, and pulses drop to 0.
- HUNT: beats without frame_sync are discarded. A beat with frame_sync: shadow[0]<=din, slot_sel<=1, state<=LOCK.
- LOCK, frame_sync=0, slot_sel!=0: shadow[slot_sel]<=din, slot_sel increments.
- Last slot (slot_sel==NCH-1): the same edge loads dout<={din, shadow[NCH-2:0]}, pulses dout_valid, and wraps slot_sel to 0. Latency: dout_valid is high in the cycle after the last slot beat is sampled.
- LOCK, slot_sel==0, frame_sync=1: normal frame start. shadow<=0, then shadow[0]<=din, slot_sel<=1.
- LOCK, slot_sel==0, frame_sync=0: lost sync. frame_err pulse, bit discarded, state<=HUNT, locked<=0.
- LOCK, slot_sel!=0, frame_sync=1: early sync. frame_err pulse, partial frame discarded (no dout_valid), treated as new slot 0. shadow cleared, shadow[0]<=din, slot_sel<=1, stays LOCK.
- dout holds its value between dout_valid pulses, including across HUNT.
- Reset mid-frame: partial frame lost; dout returns to 0.

Optional Feature:
TDM_PARITY_EN:
- Defined: each frame has NCH+1 slots. Slot NCH carries even parity over the NCH data bits, and SELW grows to cover NCH. dout and dout_valid update on the parity beat only if parity is correct. On mismatch, an extra output parity_err (1 bit) pulses, dout holds, and state stays LOCK.
- Undefined: no parity slot and no parity_err port. Behaviour is exactly as above.

Decomposition:
- Package tdm_pkg: state enum (HUNT, LOCK), default NCH, a frame-length function (NCH or NCH+1 under TDM_PARITY_EN).
- Sub-module tdm_slot_counter: modulo-frame-length counter with enable, sync-load-to-1 and wrap flag.
- The top holds the FSM, shadow register and output register.

Test Plan:
- Reset, then NCH=8 frame with sync on first beat, bits slot0..7=1,0,1,1,0,0,1,0 -> dout=8'b0100_1101, dout_valid one cycle after the 8th beat, locked=1.
- Frame 0xA5 then frame 0x3C back-to-back, sync each slot 0, din_valid gapped with random low cycles -> two dout_valid pulses, dout=0xA5 then 0x3C, gaps do not shift slots.
- Beats 0x00 without sync, then a sync frame 0xFF -> no dout_valid until after the sync frame, then dout=0xFF.
- Sync asserted again at slot 4 mid-frame -> frame_err pulse, no dout_valid for the partial frame, the following 8 beats produce a correct word.
- Missing sync at the start of the second frame -> frame_err, locked=0, dout keeps its first value; a later sync relocks.
- rst_n low at slot 5 -> dout=0, slot_sel=0, state HUNT immediately, without waiting for clk. With TDM_PARITY_EN, a bad parity bit -> parity_err, dout unchanged.
